stacked_array_driver: RTL and testbench
=======================================

Name: stacked_array_driver

Overview:
- Sequencer on the host side of the stacked systolic array's interface.
- Packs a serial stream of signed samples into one lane-packed input vector.
- Drives the array's clock-enable, ctrl and weight address, holds each vector for the array latency, then captures the packed output and returns it over a valid/ready stream.
- One vector in flight at a time; a frame is frame_len vectors and ends with a done pulse.

Parameters:
- WIDTH, 8, bits per sample/lane
- ARRAY_COUNT, 3, lanes per vector (systolic arrays in the stack)
- CELL_MEM_ADDR_WIDTH, 4, width of weight-set address
- PIPE_LATENCY, 3, ce-enabled cycles from stable x_ins to valid y_out (>=1)
- FRAME_LEN_WIDTH, 16, width of frame_len

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  begin frame; sampled only in IDLE
- frame_len  in  FRAME_LEN_WIDTH  vectors in frame, latched on start
- weight_set  in  CELL_MEM_ADDR_WIDTH  weight address, latched on start
- ctrl_cfg  in  32  array ctrl word, latched on start
- s_valid  in  1  sample valid
- s_ready  out  1  sample accepted when s_valid&&s_ready
- s_data  in  WIDTH  signed sample
- arr_ce  out  1  array clock enable
- arr_ctrl  out  32  to array ctrl
- arr_mem_addr  out  CELL_MEM_ADDR_WIDTH  to array mem_addr
- arr_x_ins  out  WIDTH*ARRAY_COUNT  packed vector, lane i at [(i+1)*WIDTH-1:i*WIDTH]
- arr_y_out  in  WIDTH*ARRAY_COUNT  packed array result
- m_valid  out  1  result valid
- m_ready  in  1  result accepted when m_valid&&m_ready
- m_data  out  WIDTH*ARRAY_COUNT  captured result
- busy  out  1  high in any state but IDLE
- done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset: state IDLE; s_ready, arr_ce, m_valid, busy, done = 0; arr_x_ins, m_data, arr_ctrl, arr_mem_addr, lane and vector counters = 0.
- IDLE: start=1 latches frame_len, weight_set, ctrl_cfg into arr_* registers.
  - frame_len=0 -> DONE.
  - else -> GATHER, lane_cnt=0, vec_cnt=0.
- GATHER: s_ready=1. Each handshake writes s_data into lane lane_cnt (lane 0 first = LSBs) and increments lane_cnt.
  - s_valid low stalls, no side effects.
  - Handshake on lane ARRAY_COUNT-1 -> ISSUE, lat_cnt=0.
  - s_ready is 0 in all other states.
- ISSUE: arr_ce=1 every cycle; arr_x_ins held constant; lat_cnt increments.
  - At lat_cnt=PIPE_LATENCY-1: capture arr_y_out into m_data on that edge -> OUTPUT.
  - Exactly PIPE_LATENCY ce cycles per vector.
- OUTPUT: arr_ce=0; m_valid=1; m_data and arr_x_ins held stable while m_ready=0.
  - On handshake: vec_cnt+1.
  - vec_cnt+1==frame_len -> DONE.
  - else -> GATHER with lane_cnt=0.
- DONE: done=1 for exactly one cycle -> IDLE. busy is 0 in the following cycle.
- start outside IDLE is ignored; latched config is unchanged for the whole frame.
- Latency: last-sample handshake to m_valid = PIPE_LATENCY+1 cycles.
- Counters: lane_cnt is clog2(ARRAY_COUNT) wide; vec_cnt is FRAME_LEN_WIDTH wide. frame_len = all-ones must complete without wrap.
- No arithmetic on data; samples pass bit-exact into lanes and results pass bit-exact out.
- rst asserted mid-frame: next edge returns to reset values.
  - Any partially gathered vector is discarded; no done pulse.
  - The array itself is not reset, but ce drops immediately.

Decomposition:
- Shared package/header holds:
  - state encodings IDLE/GATHER/ISSUE/OUTPUT/DONE
  - lane slice macro (i*WIDTH base)
  - default WIDTH/ARRAY_COUNT/CELL_MEM_ADDR_WIDTH, kept common with the array stack
- One sub-module is natural: stacked_array_lane_packer, a serial-to-parallel lane register with lane counter and full flag, reused for any future lane-packed bus.

Test Plan:
- Frame_len=1, ARRAY_COUNT=3, samples 0x05,0xFB,0x7F, array model returns y_out=x_ins -> arr_x_ins=0x7FFB05; arr_ce high exactly 3 cycles; m_data=0x7FFB05; done one cycle after m handshake.
- s_valid gapped (one beat every 3 cycles) -> lanes fill in order; no arr_ce until lane 2 taken; result identical to gap-free run.
- m_ready held low 10 cycles in OUTPUT -> m_valid stays 1, m_data stable, arr_ce=0, s_ready=0; handshake then resumes GATHER.
- start with frame_len=0 -> busy 1 cycle, done pulse, no arr_ce, no m_valid.
- Frame_len=4 with start re-asserted and weight_set changed mid-frame -> arr_mem_addr/arr_ctrl keep start-time values; exactly 4 results; one done.
- rst asserted during ISSUE (lat_cnt=1) -> next cycle all outputs zero, state IDLE; a new frame after reset produces correct m_data.

Source files
------------

// File: rtl/stacked_array_driver_pkg.sv
// Shared definitions for the stacked systolic array host-side driver.
// Default geometry is kept common with the array stack itself.
package stacked_array_driver_pkg;

    localparam int unsigned DEF_WIDTH               = 8;
    localparam int unsigned DEF_ARRAY_COUNT         = 3;
    localparam int unsigned DEF_CELL_MEM_ADDR_WIDTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GATHER,
        ST_ISSUE,
        ST_OUTPUT,
        ST_DONE
    } state_t;

    // Base bit of lane 'lane' in a lane-packed bus (lane 0 at the LSBs).
    function automatic int unsigned lane_base(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

    // Counter width that stays legal for a count of one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stacked_array_lane_packer.sv
// Serial-to-parallel lane register: fills lanes 0..LANES-1 in order,
// raises full after the last lane until cleared.
module stacked_array_lane_packer
    import stacked_array_driver_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned LANES = DEF_ARRAY_COUNT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH*LANES-1:0]   lanes,
    output logic                     last,
    output logic                     full
);

    localparam int unsigned LANE_W = cnt_width(LANES);

    logic [LANE_W-1:0] lane_cnt;

    assign last = (lane_cnt == LANE_W'(LANES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            lanes    <= '0;
            lane_cnt <= '0;
            full     <= 1'b0;
        end else if (clr) begin
            lane_cnt <= '0;
            full     <= 1'b0;
        end else if (wr_en && !full) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (lane_cnt == LANE_W'(i)) begin
                    lanes[lane_base(i, WIDTH) +: WIDTH] <= wr_data;
                end
            end
            if (last) begin
                lane_cnt <= '0;
                full     <= 1'b1;
            end else begin
                lane_cnt <= lane_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stacked_array_driver.sv
// Host-side sequencer for the stacked systolic array: gathers samples into a
// lane-packed vector, runs it through the array, and streams the result out.
module stacked_array_driver
    import stacked_array_driver_pkg::*;
#(
    parameter int unsigned WIDTH               = DEF_WIDTH,
    parameter int unsigned ARRAY_COUNT         = DEF_ARRAY_COUNT,
    parameter int unsigned CELL_MEM_ADDR_WIDTH = DEF_CELL_MEM_ADDR_WIDTH,
    parameter int unsigned PIPE_LATENCY        = 3,
    parameter int unsigned FRAME_LEN_WIDTH     = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [FRAME_LEN_WIDTH-1:0]      frame_len,
    input  logic [CELL_MEM_ADDR_WIDTH-1:0]  weight_set,
    input  logic [31:0]                     ctrl_cfg,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [WIDTH-1:0]                s_data,
    output logic                            arr_ce,
    output logic [31:0]                     arr_ctrl,
    output logic [CELL_MEM_ADDR_WIDTH-1:0]  arr_mem_addr,
    output logic [WIDTH*ARRAY_COUNT-1:0]    arr_x_ins,
    input  logic [WIDTH*ARRAY_COUNT-1:0]    arr_y_out,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [WIDTH*ARRAY_COUNT-1:0]    m_data,
    output logic                            busy,
    output logic                            done
);

    localparam int unsigned LAT_W = cnt_width(PIPE_LATENCY);

    state_t                     state, state_nxt;
    logic [FRAME_LEN_WIDTH-1:0] frame_len_r;
    logic [FRAME_LEN_WIDTH-1:0] vec_cnt;
    logic [LAT_W-1:0]           lat_cnt;

    logic pk_clr, pk_wr, pk_last, pk_full;
    logic lat_last, m_hs, last_vec;

    stacked_array_lane_packer #(
        .WIDTH (WIDTH),
        .LANES (ARRAY_COUNT)
    ) u_packer (
        .clk     (clk),
        .rst     (rst),
        .clr     (pk_clr),
        .wr_en   (pk_wr),
        .wr_data (s_data),
        .lanes   (arr_x_ins),
        .last    (pk_last),
        .full    (pk_full)
    );

    assign s_ready  = (state == ST_GATHER) && !pk_full;
    assign arr_ce   = (state == ST_ISSUE);
    assign m_valid  = (state == ST_OUTPUT);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    assign pk_wr    = s_valid && s_ready;
    assign lat_last = (lat_cnt == LAT_W'(PIPE_LATENCY - 1));
    assign m_hs     = m_valid && m_ready;
    // Extra bit keeps the compare exact when frame_len is all-ones.
    assign last_vec = (({1'b0, vec_cnt} + 1'b1) == {1'b0, frame_len_r});

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pk_clr    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    pk_clr    = 1'b1;
                    state_nxt = (frame_len == '0) ? ST_DONE : ST_GATHER;
                end
            end
            ST_GATHER: begin
                if (pk_wr && pk_last) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (lat_last) begin
                    state_nxt = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (m_hs) begin
                    pk_clr    = 1'b1;
                    state_nxt = last_vec ? ST_DONE : ST_GATHER;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_len_r  <= '0;
            arr_ctrl     <= '0;
            arr_mem_addr <= '0;
            vec_cnt      <= '0;
            lat_cnt      <= '0;
            m_data       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        frame_len_r  <= frame_len;
                        arr_ctrl     <= ctrl_cfg;
                        arr_mem_addr <= weight_set;
                        vec_cnt      <= '0;
                    end
                end
                ST_GATHER: begin
                    if (pk_wr && pk_last) begin
                        lat_cnt <= '0;
                    end
                end
                ST_ISSUE: begin
                    lat_cnt <= lat_cnt + 1'b1;
                    if (lat_last) begin
                        m_data <= arr_y_out;
                    end
                end
                ST_OUTPUT: begin
                    if (m_hs) begin
                        vec_cnt <= vec_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stacked_array_driver.sv
// Randomised scoreboard bench for stacked_array_driver with a small array model.
module tb_stacked_array_driver;

    localparam int W   = 8;
    localparam int AC  = 3;
    localparam int AW  = 4;
    localparam int PL  = 3;
    localparam int FLW = 16;
    localparam int VW  = W * AC;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [FLW-1:0] frame_len = '0;
    logic [AW-1:0]  weight_set = '0;
    logic [31:0]    ctrl_cfg = '0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [W-1:0]   s_data = '0;
    logic           arr_ce;
    logic [31:0]    arr_ctrl;
    logic [AW-1:0]  arr_mem_addr;
    logic [VW-1:0]  arr_x_ins;
    logic [VW-1:0]  arr_y_out;
    logic           m_valid;
    logic           m_ready = 1'b1;
    logic [VW-1:0]  m_data;
    logic           busy;
    logic           done;

    always #5 clk = ~clk;

    stacked_array_driver #(
        .WIDTH               (W),
        .ARRAY_COUNT         (AC),
        .CELL_MEM_ADDR_WIDTH (AW),
        .PIPE_LATENCY        (PL),
        .FRAME_LEN_WIDTH     (FLW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .frame_len    (frame_len),
        .weight_set   (weight_set),
        .ctrl_cfg     (ctrl_cfg),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .arr_ce       (arr_ce),
        .arr_ctrl     (arr_ctrl),
        .arr_mem_addr (arr_mem_addr),
        .arr_x_ins    (arr_x_ins),
        .arr_y_out    (arr_y_out),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .busy         (busy),
        .done         (done)
    );

    // Array model: PL-1 ce-gated stages, output XOR-ed with a per-frame mask so
    // a result that bypasses the array (or is taken too early) is visible.
    logic [VW-1:0] pipe [PL-1];
    logic [VW-1:0] y_mask = '0;
    always @(posedge clk) begin
        if (arr_ce) begin
            pipe[0] <= arr_x_ins;
            for (int i = 1; i < PL - 1; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign arr_y_out = pipe[PL-2] ^ y_mask;

    int            checks = 0;
    int            passes = 0;
    int            ce_run = 0;
    int            res_cnt = 0;
    int            done_cnt = 0;
    int            cyc = 0;
    int            hs_cyc = 0;
    int            mready_mode = 0;
    bit            zero_frame = 1'b0;
    logic [VW-1:0] exp_q [$];
    logic [VW-1:0] mon_x;
    logic [31:0]   cur_ctrl = '0;
    logic [AW-1:0] cur_addr = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    always @(posedge clk) cyc++;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (mready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Monitor: the scoreboard front is always the vector currently in flight.
    always @(negedge clk) begin
        if (!rst) begin
            if (arr_ce) begin
                if (ce_run == 0) begin
                    if (exp_q.size() == 0) fail_now("x_ins_unexpected_ce");
                    else chk("x_ins", arr_x_ins, exp_q[0]);
                end
                ce_run++;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("m_valid_unexpected");
                end else begin
                    mon_x = exp_q.pop_front();
                    chk("m_data", m_data, mon_x ^ y_mask);
                end
                chk("ce_cycles", ce_run, PL);
                chk("arr_ctrl", arr_ctrl, cur_ctrl);
                chk("arr_mem_addr", arr_mem_addr, cur_addr);
                ce_run = 0;
                res_cnt++;
                hs_cyc = cyc;
            end
            if (done && !zero_frame) chk("done_timing", cyc - hs_cyc, 1);
            if (done) done_cnt++;
        end
    end

    task automatic send_sample(input logic [W-1:0] d, input int gap);
        int n;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        n = 0;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 500) begin
                fail_now("s_ready_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = W'($urandom);
    endtask

    task automatic send_vec(input logic [VW-1:0] x, input int gap_lo, input int gap_hi);
        exp_q.push_back(x);
        for (int i = 0; i < AC; i++) send_sample(x[i*W +: W], $urandom_range(gap_lo, gap_hi));
    endtask

    task automatic do_start(input int len, input logic [AW-1:0] ws, input logic [31:0] cfg);
        start      = 1'b1;
        frame_len  = FLW'(len);
        weight_set = ws;
        ctrl_cfg   = cfg;
        cur_ctrl   = cfg;
        cur_addr   = ws;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic finish_frame(input int r0, input int d0, input int len);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == d0) fail_now("done_timeout");
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("results", res_cnt - r0, len);
        chk("done_pulses", done_cnt - d0, 1);
        chk("busy_after_done", busy, 1'b0);
    endtask

    task automatic run_frame(input int len, input int gap_hi, input bit noisy);
        int r0, d0;
        logic [31:0]   cfg;
        logic [AW-1:0] ws;
        r0  = res_cnt;
        d0  = done_cnt;
        cfg = $urandom;
        ws  = AW'($urandom);
        do_start(len, ws, cfg);
        for (int v = 0; v < len; v++) begin
            if (noisy) begin
                start      = 1'b1;
                weight_set = ~ws;
                ctrl_cfg   = ~cfg;
                frame_len  = FLW'($urandom);
            end
            send_vec(VW'($urandom), 0, gap_hi);
        end
        start = 1'b0;
        finish_frame(r0, d0, len);
    endtask

    initial begin
        int r0, d0, k, n;
        logic [VW-1:0] hx;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_flags", {s_ready, arr_ce, m_valid, busy, done}, 5'b0);
        chk("rst_data", {arr_x_ins, m_data}, '0);
        chk("rst_cfg", {arr_ctrl, arr_mem_addr}, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed single vector, identity array, then the same vector gapped.
        y_mask = '0;
        for (int g = 0; g < 2; g++) begin
            r0 = res_cnt;
            d0 = done_cnt;
            do_start(1, AW'(4'h3), 32'hA5A5_0001);
            send_vec(24'h7FFB05, 2 * g, 2 * g);
            finish_frame(r0, d0, 1);
        end

        // m_ready held low in OUTPUT, then released; the second vector resumes.
        y_mask = VW'($urandom);
        r0 = res_cnt;
        d0 = done_cnt;
        mready_mode = 2;
        do_start(2, AW'(4'h9), 32'h1234_5678);
        hx = VW'($urandom);
        send_vec(hx, 0, 1);
        n = 0;
        while (!m_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!m_valid) fail_now("m_valid_timeout");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold", {m_valid, arr_ce, s_ready, m_data}, {1'b1, 1'b0, 1'b0, hx ^ y_mask});
        end
        mready_mode = 0;
        @(posedge clk);
        #1;
        send_vec(VW'($urandom), 0, 2);
        finish_frame(r0, d0, 2);

        // Zero-length frame: one busy cycle with done, no array activity.
        zero_frame = 1'b1;
        do_start(0, AW'(4'h5), 32'hDEAD_BEEF);
        @(negedge clk);
        chk("zero_len_done", {busy, done, arr_ce, m_valid}, 4'b1100);
        @(negedge clk);
        chk("zero_len_idle", {busy, done, arr_ce, m_valid}, 4'b0000);
        @(posedge clk);
        #1;
        zero_frame = 1'b0;

        // Config must hold its start-time value despite start re-asserted mid-frame.
        y_mask = VW'($urandom);
        run_frame(4, 3, 1'b1);

        // Reset in the second ce cycle of a vector.
        do_start(2, AW'(4'hC), 32'h0F0F_0F0F);
        send_vec(VW'($urandom), 0, 0);
        k = 0;
        n = 0;
        while (k < 2 && n < 200) begin
            @(negedge clk);
            if (arr_ce) k++;
            n++;
        end
        if (k < 2) fail_now("ce_timeout");
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_flags", {s_ready, arr_ce, m_valid, busy, done}, 5'b0);
        chk("midrst_data", {arr_x_ins, m_data}, '0);
        chk("midrst_cfg", {arr_ctrl, arr_mem_addr}, '0);
        exp_q.delete();
        ce_run = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_frame(1, 1, 1'b0);

        // Randomised frames with random back-pressure.
        mready_mode = 1;
        for (int f = 0; f < 8; f++) begin
            y_mask = VW'($urandom);
            run_frame($urandom_range(1, 5), $urandom_range(0, 3), f[0]);
        end
        mready_mode = 0;
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
